// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and a start/busy handshake.
// Define MDU_DIV_EN to build the divider; without it div/divu are treated as no-ops.
module md_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;

  // Full-width products of the latched operands; only consumed at the commit edge.
  always_comb begin
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

`ifdef MDU_DIV_EN
  logic             div_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs, uq, ur, quo, rem;

  // Sign-magnitude divide: truncate toward zero, remainder takes the dividend's sign.
  // Most-negative / -1 naturally yields quotient = most-negative, remainder = 0.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[WIDTH-1];
    b_neg      = div_signed & b_q[WIDTH-1];
    a_abs      = a_neg ? -a_q : a_q;
    b_abs      = b_neg ? -b_q : b_q;
    uq         = (b_abs != '0) ? (a_abs / b_abs) : '0;
    ur         = (b_abs != '0) ? (a_abs % b_abs) : '0;
    quo        = (a_neg ^ b_neg) ? -uq : uq;
    rem        = a_neg ? -ur : ur;
  end
`endif

  // Next-state, launch and commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (mdOp)
            OP_MULT, OP_MULTU: begin
              a_d     = srcA;
              b_d     = srcB;
              op_d    = mdOp;
              cnt_d   = CW'(MUL_CYCLES);
              state_d = RUN;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              a_d     = srcA;
              b_d     = srcB;
              op_d    = mdOp;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
`endif
            OP_MTHI: hi_d = srcA;
            OP_MTLO: lo_d = srcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              // A zero divisor burns the full latency but leaves HI/LO untouched.
              if (b_q != '0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and busy length,
// a monitor checks them whenever busy falls; MDU_DIV_EN selects the divide checks.
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
    .srcA(srcA), .srcB(srcB), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic rst_edge = 1'b0;
  logic prev_busy = 1'b0;
  int   bcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int n, input string name);
    exp_t e;
    e.hi = h; e.lo = l; e.n = n; e.name = name;
    sb.push_back(e);
  endtask

  // Drive one start for a single edge; call at a negedge or just after a posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdOp = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
  endtask

  // Returns at the first negedge with busy low; an expired budget is a failed check.
  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy still 1, required 0", name);
    end
  endtask

  // Reset as sampled by the DUT at each edge, to tell aborts from commits.
  initial forever begin
    @(posedge clk);
    rst_edge = reset;
  end

  // Monitor: busy falling marks a commit; compare against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (prev_busy && !busy) begin
      if (rst_edge) begin
        bcnt = 0;
      end else if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_commit: got hi=%h lo=%h, required no commit", hi, lo);
        bcnt = 0;
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_hi"}, hi, mon_e.hi);
        chk({mon_e.name, "_lo"}, lo, mon_e.lo);
        chk({mon_e.name, "_busy_cycles"}, 32'(bcnt), 32'(mon_e.n));
        bcnt = 0;
      end
    end
    if (busy === 1'b1) bcnt = bcnt + 1;
    prev_busy = (busy === 1'b1);
  end

  initial begin
    logic [2:0] abort_op;
    reset = 1'b1; start = 1'b0; mdOp = 3'd0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    @(negedge clk);
    push(32'hFFFFFFFE, 32'h00000001, 5, "multu_max");
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max");

    // Operands change during RUN; the latched ones must be used.
    push(32'hFFFFFFFF, 32'hFFFFFFEB, 5, "mult_m3x7");
    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
    srcA = 32'h00012345; srcB = 32'h00000999;
    wait_done("mult_m3x7");

    // Issued in the first cycle busy is low.
    push(32'h40000000, 32'h00000000, 5, "mult_b2b_minsq");
    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done("mult_b2b_minsq");

    // mthi then mtlo on consecutive edges.
    start = 1'b1; mdOp = OP_MTHI; srcA = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_busy", 32'(busy), 32'h0);
    mdOp = OP_MTLO; srcA = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi_kept", hi, 32'hDEADBEEF);
    chk("mtlo_busy", 32'(busy), 32'h0);

    // mtlo during RUN must be ignored.
    @(negedge clk);
    push(32'h00000000, 32'h00000006, 5, "mult_2x3");
    issue(OP_MULT, 32'h2, 32'h3);
    issue(OP_MTLO, 32'h00000055, 32'h0);
    chk("mtlo_in_run_ignored", lo, 32'h12345678);
    wait_done("mult_2x3");

`ifdef MDU_DIV_EN
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2");
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
    wait_done("div_m7_2");

    push(32'h00000000, 32'h80000000, 10, "div_ovf");
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf");

    push(32'h00000002, 32'h0000000E, 10, "divu_100_7");
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7");

    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h22, 32'h0);
    push(32'h00000011, 32'h00000022, 10, "divu_by0");
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done("divu_by0");
    abort_op = OP_DIV;
`else
    issue(OP_DIV, 32'd8, 32'd2);
    chk("div_off_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("div_off_busy_later", 32'(busy), 32'h0);
    chk("div_off_hi", hi, 32'h0);
    chk("div_off_lo", lo, 32'h6);
    abort_op = OP_MULT;
`endif

    // Reset sampled on the third busy cycle aborts the operation.
    @(negedge clk);
    issue(abort_op, 32'd100, 32'd3);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_commit_hi", hi, 32'h0);
    chk("abort_no_commit_lo", lo, 32'h0);
    chk("abort_no_commit_busy", 32'(busy), 32'h0);

    push(32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult_5xm3");
    issue(OP_MULT, 32'd5, 32'hFFFFFFFD);
    wait_done("mult_5xm3");

    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
